// File: rtl/apb_soc_timer.sv
// APB timer slave: prescaled 32-bit compare timer with sticky irq
// and a free-running 64-bit cycle counter with hi-word shadow.
module apb_soc_timer #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int PRESC_WIDTH    = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      psel,
    input  logic                      penable,
    input  logic                      pwrite,
    input  logic [APB_ADDR_WIDTH-1:0] paddr,
    input  logic [31:0]               pwdata,
    output logic [31:0]               prdata,
    output logic                      pready,
    output logic                      pslverr,
    output logic                      irq_o
);

    localparam logic [2:0] A_CTRL  = 3'd0;
    localparam logic [2:0] A_COUNT = 3'd1;
    localparam logic [2:0] A_CMP   = 3'd2;
    localparam logic [2:0] A_STAT  = 3'd3;
    localparam logic [2:0] A_CYLO  = 3'd4;
    localparam logic [2:0] A_CYHI  = 3'd5;

    logic                   en_q, en_d;
    logic                   os_q, os_d;
    logic                   ie_q, ie_d;
    logic [PRESC_WIDTH-1:0] presc_q, presc_d;
    logic [PRESC_WIDTH-1:0] pcnt_q, pcnt_d;
    logic [31:0]            count_q, count_d;
    logic [31:0]            cmp_q, cmp_d;
    logic                   pend_q, pend_d;
    logic [63:0]            cyc_q, cyc_d;
    logic [31:0]            cyhi_q, cyhi_d;

    logic       access;
    logic       addr_ok;
    logic [2:0] idx;
    logic       wr_ok;
    logic       rd_ok;
    logic       sel_ctrl, sel_count, sel_cmp;
    logic       sel_stat, sel_cylo, sel_cyhi;
    logic       wr_ctrl, wr_count, wr_cmp, wr_stat;
    logic       rd_cylo;
    logic       tick;
    logic       hit;
    logic [31:0] rdata;
    logic        unused_paddr;

    assign unused_paddr = ^paddr[APB_ADDR_WIDTH-1:5];

    assign idx     = paddr[4:2];
    assign access  = psel & penable;
    assign addr_ok = (paddr[1:0] == 2'b00) && (idx <= A_CYHI);
    assign wr_ok   = access & pwrite & addr_ok;
    assign rd_ok   = access & ~pwrite & addr_ok;

    assign sel_ctrl  = (idx == A_CTRL);
    assign sel_count = (idx == A_COUNT);
    assign sel_cmp   = (idx == A_CMP);
    assign sel_stat  = (idx == A_STAT);
    assign sel_cylo  = (idx == A_CYLO);
    assign sel_cyhi  = (idx == A_CYHI);

    assign wr_ctrl  = wr_ok & sel_ctrl;
    assign wr_count = wr_ok & sel_count;
    assign wr_cmp   = wr_ok & sel_cmp;
    assign wr_stat  = wr_ok & sel_stat;
    assign rd_cylo  = rd_ok & sel_cylo;

    assign tick = en_q && (pcnt_q == presc_q);
    // A COUNT write overrides the tick, so it also suppresses the hit.
    assign hit  = tick && (count_q == cmp_q) && !wr_count;

    always_comb begin
        en_d    = en_q;
        os_d    = os_q;
        ie_d    = ie_q;
        presc_d = presc_q;
        pcnt_d  = pcnt_q;
        count_d = count_q;
        cmp_d   = cmp_q;
        pend_d  = pend_q;
        cyc_d   = cyc_q + 64'd1;
        cyhi_d  = cyhi_q;

        if (!en_q || tick) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + PRESC_WIDTH'(1);
        end

        if (wr_count) begin
            count_d = pwdata;
            pcnt_d  = '0;
        end else if (tick) begin
            if (count_q == cmp_q) begin
                count_d = '0;
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        if (wr_ctrl) begin
            en_d    = pwdata[0];
            os_d    = pwdata[1];
            ie_d    = pwdata[2];
            presc_d = pwdata[8 +: PRESC_WIDTH];
            if (!en_q && pwdata[0]) begin
                pcnt_d = '0;
            end
        end

        if (hit && os_q) begin
            en_d = 1'b0;
        end

        if (wr_cmp) begin
            cmp_d = pwdata;
        end

        if (wr_stat && pwdata[0]) begin
            pend_d = 1'b0;
        end
        if (hit) begin
            pend_d = 1'b1;
        end

        if (rd_cylo) begin
            cyhi_d = cyc_q[63:32];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_q    <= 1'b0;
            os_q    <= 1'b0;
            ie_q    <= 1'b0;
            presc_q <= '0;
            pcnt_q  <= '0;
            count_q <= '0;
            cmp_q   <= '0;
            pend_q  <= 1'b0;
            cyc_q   <= '0;
            cyhi_q  <= '0;
        end else begin
            en_q    <= en_d;
            os_q    <= os_d;
            ie_q    <= ie_d;
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
            count_q <= count_d;
            cmp_q   <= cmp_d;
            pend_q  <= pend_d;
            cyc_q   <= cyc_d;
            cyhi_q  <= cyhi_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (access && addr_ok) begin
            unique case (1'b1)
                sel_ctrl: begin
                    rdata[0] = en_q;
                    rdata[1] = os_q;
                    rdata[2] = ie_q;
                    rdata[8 +: PRESC_WIDTH] = presc_q;
                end
                sel_count: rdata = count_q;
                sel_cmp:   rdata = cmp_q;
                sel_stat:  rdata[0] = pend_q;
                sel_cylo:  rdata = cyc_q[31:0];
                sel_cyhi:  rdata = cyhi_q;
                default:   rdata = '0;
            endcase
        end
    end

    assign prdata  = rdata;
    assign pready  = 1'b1;
    assign pslverr = access & ~addr_ok;
    assign irq_o   = pend_q & ie_q;

endmodule

// File: tb/tb_apb_soc_timer.sv
// Directed + random bench for apb_soc_timer against a
// cycle-level behavioural model of the register rules.
module tb_apb_soc_timer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        psel, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready, pslverr, irq_o;

    int          vec  = 0;
    int          miss = 0;
    longint      ncyc = 0;

    apb_soc_timer dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .irq_o   (irq_o)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [11:0] CTRL  = 12'h000;
    localparam logic [11:0] COUNT = 12'h004;
    localparam logic [11:0] CMP   = 12'h008;
    localparam logic [11:0] STAT  = 12'h00C;
    localparam logic [11:0] CYLO  = 12'h010;
    localparam logic [11:0] CYHI  = 12'h014;

    // Reference model state
    bit          m_en, m_os, m_ie, m_pend;
    logic [7:0]  m_presc, m_pcnt;
    logic [31:0] m_count, m_cmp, m_sh;
    logic [63:0] m_cyc;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_zero();
        m_en = 0; m_os = 0; m_ie = 0; m_pend = 0;
        m_presc = 0; m_pcnt = 0; m_count = 0; m_cmp = 0;
        m_sh = 0; m_cyc = 0;
    endfunction

    function automatic void m_read(input logic [11:0] a,
                                   output logic [31:0] v,
                                   output bit err);
        int i;
        i   = int'(a[4:2]);
        err = (a[1:0] != 2'b00) || (i > 5);
        v   = 32'h0;
        if (!err) begin
            case (i)
                0: v = {16'h0, m_presc, 5'h0, m_ie, m_os, m_en};
                1: v = m_count;
                2: v = m_cmp;
                3: v = {31'h0, m_pend};
                4: v = m_cyc[31:0];
                default: v = m_sh;
            endcase
        end
    endfunction

    function automatic void m_update(input bit acc, input bit wr,
                                     input logic [11:0] a,
                                     input logic [31:0] d);
        logic [31:0] dummy;
        bit err, w, tick, hit;
        bit n_en, n_os, n_ie, n_pend;
        logic [7:0]  n_presc, n_pcnt;
        logic [31:0] n_count, n_cmp, n_sh;
        int i;
        if (rst_i) begin
            m_zero();
            return;
        end
        m_read(a, dummy, err);
        i    = int'(a[4:2]);
        w    = acc && wr && !err;
        tick = m_en && (m_pcnt == m_presc);
        hit  = tick && (m_count == m_cmp) && !(w && i == 1);
        n_en = m_en; n_os = m_os; n_ie = m_ie; n_pend = m_pend;
        n_presc = m_presc; n_count = m_count; n_cmp = m_cmp;
        n_sh = m_sh;
        n_pcnt = (m_en && !tick) ? m_pcnt + 8'd1 : 8'd0;
        if (tick) n_count = (m_count == m_cmp) ? 32'd0 : m_count + 32'd1;
        if (hit) begin
            n_pend = 1;
            if (m_os) n_en = 0;
        end
        if (w) begin
            case (i)
                0: begin
                    n_en = d[0] && !(hit && m_os);
                    n_os = d[1];
                    n_ie = d[2];
                    n_presc = d[15:8];
                    if (!m_en && d[0]) n_pcnt = 0;
                end
                1: begin n_count = d; n_pcnt = 0; end
                2: n_cmp = d;
                3: if (d[0] && !hit) n_pend = 0;
                default: ;
            endcase
        end
        if (acc && !wr && !err && i == 4) n_sh = m_cyc[63:32];
        m_en = n_en; m_os = n_os; m_ie = n_ie; m_pend = n_pend;
        m_presc = n_presc; m_pcnt = n_pcnt; m_count = n_count;
        m_cmp = n_cmp; m_sh = n_sh;
        m_cyc = m_cyc + 64'd1;
    endfunction

    task automatic step(input bit acc, input bit wr,
                        input logic [11:0] a, input logic [31:0] d,
                        output logic [31:0] rv, output logic re);
        logic [31:0] ev;
        bit ee;
        @(negedge clk_i);
        chk("irq_o", irq_o, m_pend & m_ie);
        psel = acc; penable = acc; pwrite = wr; paddr = a; pwdata = d;
        #1;
        rv = prdata;
        re = pslverr;
        if (acc) begin
            m_read(a, ev, ee);
            chk("pslverr", pslverr, ee);
            chk("pready", pready, 1'b1);
            if (!wr || ee) chk("prdata", prdata, ev);
        end
        @(posedge clk_i);
        m_update(acc, wr, a, d);
        ncyc++;
        #1;
        psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        logic [31:0] rv;
        logic re;
        step(1, 1, a, d, rv, re);
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] v);
        logic re;
        step(1, 0, a, 32'h0, v, re);
    endtask

    task automatic idle(input int n);
        logic [31:0] rv;
        logic re;
        repeat (n) step(0, 0, 12'h0, 32'h0, rv, re);
    endtask

    initial begin
        logic [31:0] v, lo1, lo2, hi;
        logic        re;
        longint      c1, c2, t1, t2;
        int          k;

        rst_i = 1; psel = 0; penable = 0; pwrite = 0;
        paddr = 0; pwdata = 0;
        m_zero();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 0;

        // Reset state
        chk("rst_irq", irq_o, 1'b0);
        for (int i = 0; i < 6; i++) begin
            rd(12'(i * 4), v);
            if (i != 4) chk("rst_rd", v, 32'h0);
        end

        // Periodic compare, presc = 3
        wr(CMP, 32'd4);
        wr(CTRL, 32'h0000_0305);
        k = 0;
        do begin idle(1); k++; end while (irq_o !== 1'b1 && k < 40);
        chk("irq_latency", k, 20);
        t1 = ncyc;
        rd(COUNT, v);
        chk("count_after_hit", v, 32'h0);
        wr(STAT, 32'h1);
        k = 0;
        do begin idle(1); k++; end while (irq_o !== 1'b1 && k < 40);
        t2 = ncyc;
        chk("irq_period", t2 - t1, 20);
        wr(CTRL, 32'h0);
        wr(STAT, 32'h1);

        // One-shot
        wr(COUNT, 32'h0);
        wr(CMP, 32'd2);
        wr(CTRL, 32'h07);
        idle(3);
        chk("os_irq", irq_o, 1'b1);
        rd(STAT, v);
        chk("os_pend", v, 32'h1);
        rd(CTRL, v);
        chk("os_ctrl", v, 32'h6);
        idle(2);
        rd(COUNT, v);
        chk("os_count", v, 32'h0);
        wr(STAT, 32'h1);
        chk("os_w1c_irq", irq_o, 1'b0);

        // Simultaneous W1C + hit, then COUNT write + hit
        wr(COUNT, 32'h0);
        wr(CMP, 32'd2);
        wr(CTRL, 32'h05);
        idle(2);
        wr(STAT, 32'h1);
        rd(STAT, v);
        chk("w1c_vs_hit", v, 32'h1);
        wr(STAT, 32'h1);
        wr(COUNT, 32'h10);
        rd(COUNT, v);
        chk("cntwr_vs_hit", v, 32'h10);
        rd(STAT, v);
        chk("cntwr_no_irq", v, 32'h0);
        wr(CTRL, 32'h0);

        // Wrap without irq
        wr(STAT, 32'h1);
        wr(CMP, 32'd5);
        wr(COUNT, 32'hFFFF_FFFE);
        wr(CTRL, 32'h05);
        idle(1);
        rd(COUNT, v);
        chk("wrap_ff", v, 32'hFFFF_FFFF);
        rd(COUNT, v);
        chk("wrap_0", v, 32'h0);
        rd(STAT, v);
        chk("wrap_noirq", v, 32'h0);
        idle(4);
        rd(STAT, v);
        chk("wrap_hit5", v, 32'h1);
        wr(CTRL, 32'h0);
        wr(STAT, 32'h1);

        // Cycle counter and shadow
        c1 = ncyc;
        rd(CYLO, lo1);
        idle(100);
        rd(CYHI, hi);
        chk("cyc_hi_shadow", hi, m_sh);
        c2 = ncyc;
        rd(CYLO, lo2);
        chk("cyc_delta", lo2 - lo1, c2 - c1);

        // Decode errors
        step(1, 0, 12'h018, 32'h0, v, re);
        chk("err18_slverr", re, 1'b1);
        chk("err18_data", v, 32'h0);
        step(1, 1, 12'h002, 32'hFFFF_FFFF, v, re);
        chk("err02_slverr", re, 1'b1);
        rd(CTRL, v);
        chk("err_ctrl_kept", v, 32'h0);
        rd(CMP, v);
        chk("err_cmp_kept", v, 32'd5);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            int r, ai;
            logic [11:0] a;
            logic [31:0] d;
            r  = int'($urandom_range(0, 9));
            ai = int'($urandom_range(0, 7));
            a  = 12'(ai * 4);
            if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
            d = $urandom;
            case (ai)
                0: d = (d & 32'hFFFF_00FA) | 32'h5
                       | (32'($urandom_range(0, 3)) << 8);
                1, 2: d = 32'($urandom_range(0, 6));
                default: ;
            endcase
            if ($urandom_range(0, 249) == 0) begin
                rst_i = 1;
                idle(1);
                rst_i = 0;
            end else if (r < 6) begin
                idle(1);
            end else begin
                step(1, r[0], a, d, v, re);
            end
        end

        // Reset in the middle of a pending irq
        wr(CMP, 32'd1);
        wr(CTRL, 32'h05);
        idle(5);
        rd(CYLO, v);
        rst_i = 1;
        idle(1);
        rst_i = 0;
        chk("midrst_irq", irq_o, 1'b0);
        rd(CTRL, v);
        chk("midrst_ctrl", v, 32'h0);
        rd(STAT, v);
        chk("midrst_stat", v, 32'h0);
        rd(CMP, v);
        chk("midrst_cmp", v, 32'h0);
        rd(CYHI, v);
        chk("midrst_cyhi", v, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
